// File: rtl/_demux4_buf_if.sv
// Handshake bundle for _demux4_buf: one producer stream in, four independent lane streams out.
// master is the surrounding producer/consumer side, slave is the demultiplexer itself.
interface _demux4_buf_if #(
   parameter int n = 32
);
   logic [1:0]   sel;
   logic         in_valid;
   logic         in_ready;
   logic [n-1:0] in;
   logic [n-1:0] out [3:0];
   logic [3:0]   out_valid;
   logic [3:0]   out_ready;

   modport master (
      output sel, in_valid, in, out_ready,
      input  in_ready, out, out_valid
   );

   modport slave (
      input  sel, in_valid, in, out_ready,
      output in_ready, out, out_valid
   );
endinterface

// File: rtl/_demux4_buf.sv
// Buffered 1-to-4 demultiplexer: each lane owns a 2-entry FIFO so a stalled consumer never blocks others.
// Optional macro DEMUX4_BYPASS_EN passes a word straight to an empty, ready lane in the same cycle.
module _demux4_buf #(
   parameter int n = 32
) (
   input logic          clk,
   input logic          reset,
   _demux4_buf_if.slave bus
);
   localparam int LANES = 4;

   logic [1:0]       count_r     [LANES];
   logic [1:0]       count_nxt_s [LANES];
   logic [n-1:0]     mem_r       [LANES][2];
   logic [LANES-1:0] wptr_r;
   logic [LANES-1:0] rptr_r;
   logic [LANES-1:0] lane_sel_s;
   logic [LANES-1:0] push_s;
   logic [LANES-1:0] pop_s;
   logic [LANES-1:0] bypass_s;
   logic             in_ready_s;

   // Lane decode; readiness depends only on the selected lane's registered occupancy
   always_comb begin
      lane_sel_s = 4'b0000;
      case (bus.sel)
         2'd0:    lane_sel_s = 4'b0001;
         2'd1:    lane_sel_s = 4'b0010;
         2'd2:    lane_sel_s = 4'b0100;
         2'd3:    lane_sel_s = 4'b1000;
         default: lane_sel_s = 4'b0000;
      endcase
      in_ready_s = (count_r[bus.sel] != 2'd2);
   end

   // Same-cycle pass-through for an empty lane whose consumer is ready
   always_comb begin
      bypass_s = 4'b0000;
`ifdef DEMUX4_BYPASS_EN
      for (int i = 0; i < LANES; i++) begin
         if (lane_sel_s[i] && bus.in_valid && bus.out_ready[i] && (count_r[i] == 2'd0)) begin
            bypass_s[i] = 1'b1;
         end else begin
            bypass_s[i] = 1'b0;
         end
      end
`else
      bypass_s = 4'b0000;
`endif
   end

   // Per-lane push/pop qualification and occupancy update
   always_comb begin
      push_s = 4'b0000;
      pop_s  = 4'b0000;
      for (int i = 0; i < LANES; i++) begin
         count_nxt_s[i] = count_r[i];
         push_s[i] = lane_sel_s[i] & bus.in_valid & in_ready_s & ~bypass_s[i];
         pop_s[i]  = (count_r[i] != 2'd0) & bus.out_ready[i];
         case ({push_s[i], pop_s[i]})
            2'b10:   count_nxt_s[i] = count_r[i] + 2'd1;
            2'b01:   count_nxt_s[i] = count_r[i] - 2'd1;
            default: count_nxt_s[i] = count_r[i];
         endcase
      end
   end

   // Head-of-lane outputs; a bypassed word overrides the (empty) FIFO head
   always_comb begin
      bus.in_ready  = in_ready_s;
      bus.out_valid = 4'b0000;
      for (int i = 0; i < LANES; i++) begin
         bus.out_valid[i] = (count_r[i] != 2'd0) | bypass_s[i];
         if (bypass_s[i]) begin
            bus.out[i] = bus.in;
         end else begin
            bus.out[i] = mem_r[i][rptr_r[i]];
         end
      end
   end

   // FIFO storage, pointers and counts; reset discards everything in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_r <= 4'b0000;
         rptr_r <= 4'b0000;
         for (int i = 0; i < LANES; i++) begin
            count_r[i]  <= 2'd0;
            mem_r[i][0] <= {n{1'b0}};
            mem_r[i][1] <= {n{1'b0}};
         end
      end else begin
         for (int i = 0; i < LANES; i++) begin
            count_r[i] <= count_nxt_s[i];
            if (push_s[i]) begin
               mem_r[i][wptr_r[i]] <= bus.in;
               wptr_r[i]           <= ~wptr_r[i];
            end
            if (pop_s[i]) begin
               rptr_r[i] <= ~rptr_r[i];
            end
         end
      end
   end
endmodule

// File: tb/tb__demux4_buf.sv
// Bench for _demux4_buf: directed scenarios then random traffic, checked against per-lane queues
// holding at most two words each (plus same-cycle pass-through when DEMUX4_BYPASS_EN is defined).
module tb__demux4_buf;
   localparam int N = 32;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [N-1:0] q [4][$];

   _demux4_buf_if #(.n(N)) bus ();

   _demux4_buf #(.n(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: apply inputs, check against the queues, then retire pops/push at the edge
   task automatic cyc(input logic v, input logic [1:0] s, input logic [N-1:0] d,
                      input logic [3:0] rdy, output logic acc);
      logic         exp_rdy;
      logic         hit;
      logic         ev;
      logic [N-1:0] ed;
      @(negedge clk);
      bus.in_valid  = v;
      bus.sel       = s;
      bus.in        = d;
      bus.out_ready = rdy;
      #1;
      exp_rdy = (q[s].size() != 2);
      chk("in_ready", N'(bus.in_ready), N'(exp_rdy));
      hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ev = (q[i].size() != 0);
         ed = '0;
         if (ev) ed = q[i][0];
`ifdef DEMUX4_BYPASS_EN
         if (q[i].size() == 0 && v && int'(s) == i && rdy[i]) begin
            ev  = 1'b1;
            ed  = d;
            hit = 1'b1;
         end
`endif
         chk($sformatf("out_valid[%0d]", i), N'(bus.out_valid[i]), N'(ev));
         if (ev) chk($sformatf("out[%0d]", i), bus.out[i], ed);
      end
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         if (rdy[i] && q[i].size() != 0) void'(q[i].pop_front());
      end
      acc = v && exp_rdy;
      if (acc && !hit) q[s].push_back(d);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset         = 1'b1;
      bus.in_valid  = 1'b1;
      bus.sel       = 2'd1;
      bus.in        = 32'hFFFF_FFFF;
      bus.out_ready = 4'hF;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      chk("rst out_valid", N'(bus.out_valid), 32'd0);
      for (int i = 0; i < 4; i++) chk($sformatf("rst out[%0d]", i), bus.out[i], 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset         = 1'b0;
      bus.out_ready = 4'h0;
      for (int i = 0; i < 4; i++) q[i].delete();
      for (int s = 0; s < 4; s++) begin
         bus.sel = 2'(s);
         #1;
         chk($sformatf("rst in_ready sel%0d", s), N'(bus.in_ready), 32'd1);
      end
   endtask

   initial begin
      logic         acc;
      logic         pv;
      logic         stall;
      logic [1:0]   ps;
      logic [N-1:0] pd;
      logic [3:0]   rdy;

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.sel       = 2'd0;
      bus.in        = 32'd0;
      bus.out_ready = 4'h0;
      do_reset();

      // single word held on lane 2 until popped
      cyc(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, acc);
      repeat (3) cyc(1'b0, 2'd0, 32'd0, 4'b0000, acc);
      cyc(1'b0, 2'd0, 32'd0, 4'b0100, acc);
      cyc(1'b0, 2'd0, 32'd0, 4'b0000, acc);

      // fill lane 1, full blocks even with a same-cycle pop, then drain in order
      cyc(1'b1, 2'd1, 32'hAAAA_0001, 4'b0000, acc);
      cyc(1'b1, 2'd1, 32'hBBBB_0002, 4'b0000, acc);
      cyc(1'b0, 2'd1, 32'd0, 4'b0000, acc);
      cyc(1'b0, 2'd0, 32'd0, 4'b0000, acc);
      cyc(1'b1, 2'd1, 32'hCCCC_0003, 4'b0010, acc);
      cyc(1'b1, 2'd1, 32'hCCCC_0003, 4'b0010, acc);
      cyc(1'b0, 2'd1, 32'd0, 4'b0010, acc);
      cyc(1'b0, 2'd1, 32'd0, 4'b0010, acc);

      // streaming into lane 3
      for (int k = 1; k <= 16; k++) cyc(1'b1, 2'd3, N'(k), 4'b1000, acc);
      repeat (2) cyc(1'b0, 2'd3, 32'd0, 4'b1000, acc);

      // lane 0 stalled full while other lanes flow, then reset mid-stream
      cyc(1'b1, 2'd0, 32'h0000_000A, 4'b1110, acc);
      cyc(1'b1, 2'd0, 32'h0000_000B, 4'b1110, acc);
      cyc(1'b1, 2'd1, 32'h0000_0010, 4'b1110, acc);
      cyc(1'b1, 2'd2, 32'h0000_0020, 4'b1110, acc);
      cyc(1'b1, 2'd3, 32'h0000_0030, 4'b1110, acc);
      repeat (2) cyc(1'b0, 2'd0, 32'd0, 4'b1110, acc);
      cyc(1'b1, 2'd2, 32'h0000_0040, 4'b0000, acc);
      do_reset();

      // empty lane 0 with a ready consumer
      cyc(1'b1, 2'd0, 32'h0000_0055, 4'b0001, acc);
      cyc(1'b0, 2'd0, 32'd0, 4'b0001, acc);
      cyc(1'b0, 2'd0, 32'd0, 4'b0000, acc);

      // random traffic; sel and data are held while stalled
      stall = 1'b0;
      pv    = 1'b0;
      ps    = 2'd0;
      pd    = 32'd0;
      for (int k = 0; k < 600; k++) begin
         if (!stall) begin
            pv = ($urandom_range(0, 3) != 0);
            ps = 2'($urandom_range(0, 3));
            pd = $urandom;
         end
         rdy = 4'($urandom_range(0, 15));
         cyc(pv, ps, pd, rdy, acc);
         stall = pv && !acc;
      end
      repeat (3) cyc(1'b0, 2'd0, 32'd0, 4'b1111, acc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
